// File: rtl/present_job_scheduler.sv
// present_job_scheduler
// Shares one PRESENT core between two requesters. Grants are round-robin.
// The scheduler loads the key and then the plaintext into the core, and waits
// for the core to finish or for the timeout to expire. It returns the result on
// the owner's valid/ready response channel. The last loaded key is cached, so a
// job that reuses it skips the key-load cycle.

module present_job_scheduler #(
    parameter int KEY_W   = 80,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 40
) (
    input  logic              inClk,
    input  logic              inRst,

    input  logic              inReq0Valid,
    input  logic [KEY_W-1:0]  inReq0Key,
    input  logic [DATA_W-1:0] inReq0Data,
    output logic              outReq0Ready,
    output logic              outRsp0Valid,
    output logic [DATA_W-1:0] outRsp0Data,
    output logic              outRsp0Err,
    input  logic              inRsp0Ready,

    input  logic              inReq1Valid,
    input  logic [KEY_W-1:0]  inReq1Key,
    input  logic [DATA_W-1:0] inReq1Data,
    output logic              outReq1Ready,
    output logic              outRsp1Valid,
    output logic [DATA_W-1:0] outRsp1Data,
    output logic              outRsp1Err,
    input  logic              inRsp1Ready,

    output logic [KEY_W-1:0]  outCoreKey,
    output logic              outCoreKeyWr,
    output logic [DATA_W-1:0] outCoreData,
    output logic              outCoreDataWr,
    input  logic              inCoreBusy,
    input  logic [DATA_W-1:0] inCoreResult,

    output logic              outBusy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_DATA,
        WAIT_START,
        WAIT_DONE,
        RESPOND
    } state_t;

    state_t state, state_next;

    // Control state
    logic              ptr;
    logic              cache_vld;
    logic [CNT_W-1:0]  tmo_cnt;

    // Job and response registers (no reset: only observed through gated outputs)
    logic              owner;
    logic [KEY_W-1:0]  job_key;
    logic [DATA_W-1:0] job_data;
    logic [KEY_W-1:0]  cache_key;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    // Arbitration and completion decode
    logic              grant_any;
    logic              grant_id;
    logic [KEY_W-1:0]  grant_key;
    logic [DATA_W-1:0] grant_data;
    logic              key_hit;
    logic              waiting;
    logic              core_done;
    logic              tmo_hit;
    logic              rsp_tmo;
    logic              rsp_ready_owner;

    // Pick the requester for this cycle and check whether its key is already in the core
    always_comb begin
        grant_any = inReq0Valid | inReq1Valid;
        if (inReq0Valid && inReq1Valid) begin
            grant_id = ptr;
        end else begin
            grant_id = inReq1Valid;
        end
        grant_key  = grant_id ? inReq1Key  : inReq0Key;
        grant_data = grant_id ? inReq1Data : inReq0Data;
        key_hit    = cache_vld && (grant_key == cache_key);
    end

    // Completion and timeout conditions; a completion that lands on the
    // timeout cycle wins over the timeout
    always_comb begin
        waiting         = (state == WAIT_START) || (state == WAIT_DONE);
        core_done       = (state == WAIT_DONE) && !inCoreBusy;
        tmo_hit         = waiting && (tmo_cnt >= CNT_W'(TIMEOUT - 1));
        rsp_tmo         = tmo_hit && !core_done;
        rsp_ready_owner = owner ? inRsp1Ready : inRsp0Ready;
    end

    // State register
    always_ff @(posedge inClk) begin
        if (inRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; every output is zero unless its state drives it
    always_comb begin
        state_next    = state;
        outReq0Ready  = 1'b0;
        outReq1Ready  = 1'b0;
        outRsp0Valid  = 1'b0;
        outRsp0Data   = '0;
        outRsp0Err    = 1'b0;
        outRsp1Valid  = 1'b0;
        outRsp1Data   = '0;
        outRsp1Err    = 1'b0;
        outCoreKey    = '0;
        outCoreKeyWr  = 1'b0;
        outCoreData   = '0;
        outCoreDataWr = 1'b0;
        outBusy       = (state != IDLE);

        unique case (state)
            IDLE: begin
                if (grant_any && !inRst) begin
                    outReq0Ready = !grant_id;
                    outReq1Ready = grant_id;
                    state_next   = key_hit ? LOAD_DATA : LOAD_KEY;
                end
            end
            LOAD_KEY: begin
                outCoreKey   = job_key;
                outCoreKeyWr = 1'b1;
                state_next   = LOAD_DATA;
            end
            LOAD_DATA: begin
                outCoreData   = job_data;
                outCoreDataWr = 1'b1;
                state_next    = WAIT_START;
            end
            WAIT_START: begin
                // The job cannot be complete before busy has been seen, so a timeout here always aborts
                if (tmo_hit) begin
                    state_next = RESPOND;
                end else if (inCoreBusy) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (core_done || tmo_hit) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                outRsp0Valid = !owner;
                outRsp1Valid = owner;
                outRsp0Data  = owner ? '0 : rsp_data;
                outRsp1Data  = owner ? rsp_data : '0;
                outRsp0Err   = !owner && rsp_err;
                outRsp1Err   = owner && rsp_err;
                if (rsp_ready_owner) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Fairness pointer, key-cache validity and timeout counter
    always_ff @(posedge inClk) begin
        if (inRst) begin
            ptr       <= 1'b0;
            cache_vld <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            if (state == LOAD_KEY) begin
                cache_vld <= 1'b1;
            end else if (rsp_tmo) begin
                // The core was abandoned mid-job, so its key register can no longer be trusted
                cache_vld <= 1'b0;
            end

            if (state == LOAD_DATA) begin
                tmo_cnt <= '0;
            end else if (waiting) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end

            if ((state == RESPOND) && rsp_ready_owner) begin
                ptr <= !owner;
            end
        end
    end

    // Job latch at grant, cached key at key load, response capture at completion
    always_ff @(posedge inClk) begin
        if ((state == IDLE) && grant_any) begin
            job_key  <= grant_key;
            job_data <= grant_data;
            owner    <= grant_id;
        end

        if (state == LOAD_KEY) begin
            cache_key <= job_key;
        end

        if (core_done) begin
            rsp_data <= inCoreResult;
            rsp_err  <= 1'b0;
        end else if (rsp_tmo) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_present_job_scheduler.sv
// Directed bench for present_job_scheduler with a behavioural PRESENT core stand-in.
module tb_present_job_scheduler;

    localparam int KEY_W   = 80;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 40;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic [KEY_W-1:0]  req0_key, req1_key;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_data, rsp1_data;
    logic              rsp0_err, rsp1_err;
    logic              rsp0_ready, rsp1_ready;
    logic [KEY_W-1:0]  core_key;
    logic              core_key_wr;
    logic [DATA_W-1:0] core_data;
    logic              core_data_wr;
    logic              core_busy;
    logic [DATA_W-1:0] core_res;
    logic              out_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // core stand-in controls
    int   core_dur  = 31;
    int   core_cnt  = 0;
    logic core_hang = 1'b0;
    logic core_kill = 1'b0;

    // strobe monitor
    int               kwr_cnt  = 0;
    int               dwr_cnt  = 0;
    int               both_cnt = 0;
    int               kwr_cyc  = -1;
    int               dwr_cyc  = -1;
    logic [KEY_W-1:0] kwr_key  = '0;
    logic [DATA_W-1:0] dwr_data = '0;

    present_job_scheduler #(.KEY_W(KEY_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .inClk(clk), .inRst(rst),
        .inReq0Valid(req0_valid), .inReq0Key(req0_key), .inReq0Data(req0_data),
        .outReq0Ready(req0_ready), .outRsp0Valid(rsp0_valid), .outRsp0Data(rsp0_data),
        .outRsp0Err(rsp0_err), .inRsp0Ready(rsp0_ready),
        .inReq1Valid(req1_valid), .inReq1Key(req1_key), .inReq1Data(req1_data),
        .outReq1Ready(req1_ready), .outRsp1Valid(rsp1_valid), .outRsp1Data(rsp1_data),
        .outRsp1Err(rsp1_err), .inRsp1Ready(rsp1_ready),
        .outCoreKey(core_key), .outCoreKeyWr(core_key_wr),
        .outCoreData(core_data), .outCoreDataWr(core_data_wr),
        .inCoreBusy(core_busy), .inCoreResult(core_res),
        .outBusy(out_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // core stand-in: busy rises after the data strobe and stays high core_dur cycles
    always @(posedge clk) begin
        if (rst || core_kill) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
        end else if (core_data_wr) begin
            core_busy <= 1'b1;
            core_cnt  <= core_dur;
        end else if (core_busy && !core_hang) begin
            if (core_cnt <= 1) core_busy <= 1'b0;
            core_cnt <= core_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (core_key_wr) begin
            kwr_cnt++;
            kwr_cyc = cyc;
            kwr_key = core_key;
        end
        if (core_data_wr) begin
            dwr_cnt++;
            dwr_cyc  = cyc;
            dwr_data = core_data;
        end
        if (core_key_wr && core_data_wr) both_cnt++;
    end

    // Present a job (caller is at a negedge) and wait for its accept pulse.
    task automatic accept(input int r, input logic [KEY_W-1:0] k, input logic [DATA_W-1:0] d,
                          output int t_acc, output logic ready_after, output bit ok);
        int n = 0;
        if (r == 0) begin req0_valid = 1'b1; req0_key = k; req0_data = d; end
        else        begin req1_valid = 1'b1; req1_key = k; req1_data = d; end
        ok = 1'b0;
        forever begin
            #1;
            if ((r == 0 && req0_ready) || (r == 1 && req1_ready)) begin ok = 1'b1; break; end
            if (n >= 300) break;
            @(negedge clk);
            n++;
        end
        t_acc = cyc;
        @(negedge clk);
        ready_after = (r == 0) ? req0_ready : req1_ready;
        if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    // Wait (bounded) for the response of requester r; stays on that negedge.
    task automatic wait_rsp(input int r, output int t_rsp, output logic [DATA_W-1:0] dat,
                            output logic err, output logic other_vld, output bit ok);
        int n = 0;
        ok = 1'b0;
        forever begin
            if ((r == 0) ? rsp0_valid : rsp1_valid) begin ok = 1'b1; break; end
            if (n >= 300) break;
            @(negedge clk);
            n++;
        end
        t_rsp     = cyc;
        dat       = (r == 0) ? rsp0_data : rsp1_data;
        err       = (r == 0) ? rsp0_err  : rsp1_err;
        other_vld = (r == 0) ? rsp1_valid : rsp0_valid;
    endtask

    task automatic handshake(input int r);
        if (r == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_key = '0; req1_key = '0;
        req0_data = '0; req1_data = '0; rsp0_ready = 0; rsp1_ready = 0;
        core_res = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
             core_key_wr, core_data_wr} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0", {out_busy, req0_ready, req1_ready,
                     rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, core_key_wr, core_data_wr});
        end
        checks++;
        if (rsp0_data !== '0) begin errors++; $display("FAIL reset_rsp0_data: got %h required 0", rsp0_data); end
        checks++;
        if (rsp1_data !== '0) begin errors++; $display("FAIL reset_rsp1_data: got %h required 0", rsp1_data); end
        checks++;
        if (core_key !== '0) begin errors++; $display("FAIL reset_core_key: got %h required 0", core_key); end
        checks++;
        if (core_data !== '0) begin errors++; $display("FAIL reset_core_data: got %h required 0", core_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int ta, tr; logic ra, err, oth; bit ok; logic [DATA_W-1:0] d;
        core_dur = 31;
        core_res = 64'h5579C1387B228445;
        accept(0, 80'h0, 64'h0, ta, ra, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_accept: got no ready0 required ready0 pulse"); end
        checks++;
        if (ra !== 1'b0) begin errors++; $display("FAIL single_ready_pulse: got %b required 0", ra); end
        wait_rsp(0, tr, d, err, oth, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_rsp_timeout: got no rsp0_valid required 1"); end
        checks++;
        if (kwr_cyc !== ta + 1) begin errors++; $display("FAIL single_key_strobe_cyc: got %0d required %0d", kwr_cyc, ta + 1); end
        checks++;
        if (dwr_cyc !== ta + 2) begin errors++; $display("FAIL single_data_strobe_cyc: got %0d required %0d", dwr_cyc, ta + 2); end
        checks++;
        if (kwr_key !== 80'h0 || dwr_data !== 64'h0) begin
            errors++; $display("FAIL single_core_bus: got key %h data %h required 0 0", kwr_key, dwr_data);
        end
        checks++;
        if (d !== 64'h5579C1387B228445) begin errors++; $display("FAIL single_rsp_data: got %h required 5579c1387b228445", d); end
        checks++;
        if (err !== 1'b0 || oth !== 1'b0) begin errors++; $display("FAIL single_err_other: got err %b other %b required 0 0", err, oth); end
        handshake(0);
    endtask

    task automatic test_key_cache;
        int ta1, tr1, ta2, tr2, k0, k1; logic ra, err, oth; bit ok1, ok2; logic [DATA_W-1:0] d;
        core_dur = 31;
        core_res = 64'hDEADBEEF00C0FFEE;
        k0 = kwr_cnt;
        accept(0, {KEY_W{1'b1}}, 64'h0123456789ABCDEF, ta1, ra, ok1);
        wait_rsp(0, tr1, d, err, oth, ok2);
        handshake(0);
        k1 = kwr_cnt;
        checks++;
        if (!ok1 || !ok2 || k1 - k0 !== 1) begin
            errors++; $display("FAIL cache_first_keyload: got %0d key strobes required 1", k1 - k0);
        end
        accept(0, {KEY_W{1'b1}}, 64'h0123456789ABCDEF, ta2, ra, ok1);
        wait_rsp(0, tr2, d, err, oth, ok2);
        checks++;
        if (!ok1 || !ok2 || kwr_cnt !== k1) begin
            errors++; $display("FAIL cache_hit_no_keyload: got %0d key strobes required 0", kwr_cnt - k1);
        end
        checks++;
        if (dwr_cyc !== ta2 + 1) begin errors++; $display("FAIL cache_hit_data_cyc: got %0d required %0d", dwr_cyc, ta2 + 1); end
        checks++;
        if ((tr1 - ta1) - (tr2 - ta2) !== 1) begin
            errors++; $display("FAIL cache_latency_saving: got %0d required 1", (tr1 - ta1) - (tr2 - ta2));
        end
        checks++;
        if (d !== 64'hDEADBEEF00C0FFEE || err !== 1'b0) begin
            errors++; $display("FAIL cache_rsp: got %h err %b required deadbeef00c0ffee err 0", d, err);
        end
        handshake(0);
    endtask

    task automatic test_round_robin;
        int tr, n, who; logic err, oth; bit ok; logic [DATA_W-1:0] d;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        core_dur = 5;
        req0_key = 80'h1; req0_data = 64'hA0;
        req1_key = 80'h2; req1_data = 64'hB1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            core_res = 64'h1000 + 64'(i);
            n = 0;
            forever begin
                #1;
                if (req0_ready || req1_ready || n >= 300) break;
                @(negedge clk);
                n++;
            end
            who = req1_ready ? 1 : 0;
            checks++;
            if (!(req0_ready ^ req1_ready) || who !== (i % 2)) begin
                errors++; $display("FAIL rr_grant_%0d: got ready0 %b ready1 %b required grant %0d", i, req0_ready, req1_ready, i % 2);
            end
            @(negedge clk);
            wait_rsp(who, tr, d, err, oth, ok);
            checks++;
            if (!ok || oth !== 1'b0 || d !== 64'h1000 + 64'(i)) begin
                errors++; $display("FAIL rr_rsp_%0d: got data %h other_valid %b required %h 0", i, d, oth, 64'h1000 + 64'(i));
            end
            handshake(who);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int ta, tr, k1; logic ra, err, oth; bit ok; logic [DATA_W-1:0] d;
        logic [KEY_W-1:0] k;
        k = 80'hA5A5_5A5A_0F0F_F0F0_1234;
        core_hang = 1'b1;
        core_res  = 64'h7777;
        accept(1, k, 64'h42, ta, ra, ok);
        wait_rsp(1, tr, d, err, oth, ok);
        checks++;
        if (!ok || tr !== dwr_cyc + 1 + TIMEOUT) begin
            errors++; $display("FAIL timeout_cycles: got %0d required %0d after WAIT_START entry", tr - dwr_cyc - 1, TIMEOUT);
        end
        checks++;
        if (d !== '0 || err !== 1'b1 || oth !== 1'b0) begin
            errors++; $display("FAIL timeout_rsp: got data %h err %b required 0 err 1", d, err);
        end
        handshake(1);
        core_hang = 1'b0;
        core_kill = 1'b1;
        @(negedge clk);
        core_kill = 1'b0;
        core_dur  = 6;
        k1 = kwr_cnt;
        accept(1, k, 64'h42, ta, ra, ok);
        wait_rsp(1, tr, d, err, oth, ok);
        checks++;
        if (!ok || kwr_cnt !== k1 + 1 || err !== 1'b0 || d !== 64'h7777) begin
            errors++; $display("FAIL timeout_reload: got %0d key strobes err %b data %h required 1 0 7777", kwr_cnt - k1, err, d);
        end
        handshake(1);
    endtask

    task automatic test_stall;
        int ta, tr, kw, dw; logic ra, err, oth; bit ok; logic [DATA_W-1:0] d;
        core_dur = 8;
        core_res = 64'hCAFEBABE12345678;
        accept(0, 80'h55, 64'h99, ta, ra, ok);
        wait_rsp(0, tr, d, err, oth, ok);
        checks++;
        if (!ok || d !== 64'hCAFEBABE12345678) begin
            errors++; $display("FAIL stall_rsp: got %h required cafebabe12345678", d);
        end
        req1_key = 80'h66; req1_data = 64'h3; req1_valid = 1'b1;
        kw = kwr_cnt; dw = dwr_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_data !== 64'hCAFEBABE12345678 || rsp0_err !== 1'b0 ||
                req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold_%0d: got valid %b data %h ready1 %b required 1 cafebabe12345678 0",
                                   i, rsp0_valid, rsp0_data, req1_ready);
            end
        end
        checks++;
        if (kwr_cnt !== kw || dwr_cnt !== dw) begin
            errors++; $display("FAIL stall_no_strobe: got %0d strobes required 0", (kwr_cnt - kw) + (dwr_cnt - dw));
        end
        handshake(0);
        core_res = 64'h0BADF00D;
        accept(1, 80'h66, 64'h3, ta, ra, ok);
        wait_rsp(1, tr, d, err, oth, ok);
        checks++;
        if (!ok || d !== 64'h0BADF00D || oth !== 1'b0) begin
            errors++; $display("FAIL stall_next_job: got %h other %b required badf00d 0", d, oth);
        end
        handshake(1);
    endtask

    task automatic test_reset_mid;
        int ta, tr, n, seen, k1; logic ra, err, oth; bit ok; logic [DATA_W-1:0] d;
        logic [KEY_W-1:0] k;
        k = 80'h12345;
        core_dur = 20;
        core_res = 64'h3C3C;
        accept(0, k, 64'h1, ta, ra, ok);
        wait_rsp(0, tr, d, err, oth, ok);
        handshake(0);
        accept(0, k, 64'h2, ta, ra, ok);
        n = 0;
        while (!core_busy && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
             core_key_wr, core_data_wr} !== 9'b0 || rsp0_data !== '0 || core_key !== '0 || core_data !== '0) begin
            errors++; $display("FAIL midreset_outputs: got busy %b rsp0_valid %b required all 0", out_busy, rsp0_valid);
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || out_busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midreset_silent: got %0d active cycles required 0", seen); end
        k1 = kwr_cnt;
        core_res = 64'h5A5A;
        accept(0, k, 64'h3, ta, ra, ok);
        wait_rsp(0, tr, d, err, oth, ok);
        checks++;
        if (!ok || kwr_cnt !== k1 + 1 || d !== 64'h5A5A) begin
            errors++; $display("FAIL midreset_reload: got %0d key strobes data %h required 1 5a5a", kwr_cnt - k1, d);
        end
        handshake(0);
    endtask

    initial begin
        test_reset;
        test_single;
        test_key_cache;
        test_round_robin;
        test_timeout;
        test_stall;
        test_reset_mid;
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d required 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
